// File: rtl/adder_arbiter_pkg.sv
// Shared sizes, types and the round-robin pick helper for the adder arbiter.
// All sizing lives here so the interface, FIFO and top always agree.
package adder_arb_pkg;

    localparam int NUM_REQ      = 4;
    localparam int C_DATA_WIDTH = 32;
    localparam int MAX_INFLIGHT = 8;
    localparam int ID_W         = $clog2(NUM_REQ);
    localparam int CNT_W        = $clog2(MAX_INFLIGHT) + 1;

    typedef logic [ID_W-1:0]  req_id_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic    found;
        req_id_t id;
    } rr_pick_t;

    // Lowest index at or after ptr (wrapping) with a valid request.
    function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] valid, input req_id_t ptr);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[idx]) begin
                r.found = 1'b1;
                r.id    = req_id_t'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Stream bundle between the requesters, the shared adder and the arbiter.
// slave = arbiter view, master = environment (requesters + adder) view.
interface adder_arbiter_if;
    import adder_arb_pkg::*;

    logic [NUM_REQ-1:0]                req_tvalid;
    logic [NUM_REQ*2*C_DATA_WIDTH-1:0] req_tdata;
    logic [NUM_REQ-1:0]                req_tready;
    logic                              add_tvalid;
    logic [2*C_DATA_WIDTH-1:0]         add_tdata;
    logic                              add_tready;
    logic                              res_tvalid;
    logic [C_DATA_WIDTH-1:0]           res_tdata;
    logic                              res_tready;
    logic [NUM_REQ-1:0]                rsp_tvalid;
    logic [NUM_REQ*C_DATA_WIDTH-1:0]   rsp_tdata;
    logic [NUM_REQ-1:0]                rsp_tready;
    cnt_t                              inflight;
    logic                              err;

    modport slave (
        input  req_tvalid, req_tdata, add_tready, res_tvalid, res_tdata, rsp_tready,
        output req_tready, add_tvalid, add_tdata, res_tready, rsp_tvalid, rsp_tdata,
               inflight, err
    );

    modport master (
        output req_tvalid, req_tdata, add_tready, res_tvalid, res_tdata, rsp_tready,
        input  req_tready, add_tvalid, add_tdata, res_tready, rsp_tvalid, rsp_tdata,
               inflight, err
    );

endinterface

// File: rtl/adder_arbiter_tag_fifo.sv
// Requester-ID FIFO with first-word-fall-through head; routes adder results
// back in issue order.
module tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only taken if the same cycle frees an entry.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin front end sharing one pipelined adder among NUM_REQ requesters;
// a tag FIFO steers each in-order result back to the requester that issued it.
module adder_arbiter
    import adder_arb_pkg::*;
(
    input  logic           aclk,
    input  logic           aresetn,
    adder_arbiter_if.slave bus
);

    logic [2*C_DATA_WIDTH-1:0] slot_q;
    logic                      slot_v;
    req_id_t                   rr_ptr;
    logic                      err_q;

    rr_pick_t                  pick;
    logic                      slot_load_ok;
    logic                      accept;
    logic [NUM_REQ-1:0]        grant_oh;

    req_id_t                   head_id;
    logic                      fifo_full;
    logic                      fifo_empty;
    cnt_t                      fifo_count;
    logic                      res_rdy;
    logic                      pop;
    logic [NUM_REQ-1:0]        rsp_v;

    // Tags are pushed on request accept, so the FIFO count already includes the
    // held slot; a slot draining this cycle frees its place, hence full alone gates.
    assign slot_load_ok = (~slot_v | bus.add_tready) & ~fifo_full;

    always_comb begin
        pick     = rr_pick(bus.req_tvalid, rr_ptr);
        accept   = slot_load_ok & pick.found;
        grant_oh = '0;
        if (accept) grant_oh[pick.id] = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            slot_q <= '0;
            slot_v <= 1'b0;
            rr_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                slot_q <= bus.req_tdata[int'(pick.id)*2*C_DATA_WIDTH +: 2*C_DATA_WIDTH];
                slot_v <= 1'b1;
                rr_ptr <= (pick.id == req_id_t'(NUM_REQ-1)) ? '0 : pick.id + 1'b1;
            end else if (bus.add_tready) begin
                slot_v <= 1'b0;
            end
            if (bus.res_tvalid & fifo_empty) err_q <= 1'b1;
        end
    end

    tag_fifo #(
        .DEPTH(MAX_INFLIGHT),
        .W    (ID_W)
    ) u_tag_fifo (
        .aclk   (aclk),
        .aresetn(aresetn),
        .push   (accept),
        .pop    (pop),
        .din    (pick.id),
        .head   (head_id),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Only the head requester may take the result; others wait (no reordering).
    always_comb begin
        rsp_v = '0;
        if (bus.res_tvalid & ~fifo_empty) rsp_v[head_id] = 1'b1;
    end

    assign res_rdy = ~fifo_empty & bus.rsp_tready[head_id];
    assign pop     = bus.res_tvalid & res_rdy;

    assign bus.req_tready = grant_oh;
    assign bus.add_tvalid = slot_v;
    assign bus.add_tdata  = slot_q;
    assign bus.res_tready = res_rdy;
    assign bus.rsp_tvalid = rsp_v;
    assign bus.rsp_tdata  = {NUM_REQ{bus.res_tdata}};
    assign bus.inflight   = fifo_count;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: behavioural queue model of arbitration/return path,
// a latency-LAT modulo-100 adder model, directed scenarios and random traffic.
module tb_adder_arbiter;
    import adder_arb_pkg::*;

    localparam int N   = NUM_REQ;
    localparam int LAT = 3;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    adder_arbiter_if bus();

    adder_arbiter dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [N-1:0] d_req_v;
    logic [N-1:0] d_rsp_rdy;
    logic [31:0]  d_a [N];
    logic [31:0]  d_b [N];
    logic         d_add_rdy;
    logic         d_force_res;

    // model: tags/sums in issue order, issue slot, rr pointer, sticky error
    int          m_tags [$];
    int          m_sums [$];
    logic        m_slot_v;
    logic [63:0] m_slot_d;
    int          m_rr;
    logic        m_err;

    int ad_sum [$];
    int ad_rdy [$];

    logic [N-1:0] s_req_tready;
    logic [N-1:0] s_rsp_tvalid;
    logic         s_add_tvalid;
    logic         s_res_tready;
    logic         s_err;
    logic [63:0]  s_add_tdata;
    logic [127:0] s_rsp_tdata;
    cnt_t         s_inflight;

    int acc;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_tags.delete();
        m_sums.delete();
        m_slot_v = 1'b0;
        m_slot_d = '0;
        m_rr     = 0;
        m_err    = 1'b0;
        ad_sum.delete();
        ad_rdy.delete();
        d_req_v     = '0;
        d_rsp_rdy   = '1;
        d_add_rdy   = 1'b1;
        d_force_res = 1'b0;
    endtask

    task automatic sample();
        s_req_tready = bus.req_tready;
        s_rsp_tvalid = bus.rsp_tvalid;
        s_add_tvalid = bus.add_tvalid;
        s_add_tdata  = bus.add_tdata;
        s_res_tready = bus.res_tready;
        s_rsp_tdata  = bus.rsp_tdata;
        s_inflight   = bus.inflight;
        s_err        = bus.err;
    endtask

    task automatic step();
        logic         res_v;
        logic [31:0]  res_d;
        logic         load_ok;
        int           g;
        int           head;
        logic [N-1:0] exp_rt;
        logic [N-1:0] exp_rv;
        logic         exp_rr;
        logic         pop;
        @(negedge aclk);
        res_v = d_force_res || (ad_sum.size() > 0 && ad_rdy[0] <= cyc);
        res_d = d_force_res ? 32'hdead_beef : (ad_sum.size() > 0 ? 32'(ad_sum[0]) : 32'h0);
        bus.req_tvalid = d_req_v;
        for (int i = 0; i < N; i++) bus.req_tdata[i*64 +: 64] = {d_b[i], d_a[i]};
        bus.add_tready = d_add_rdy;
        bus.res_tvalid = res_v;
        bus.res_tdata  = res_d;
        bus.rsp_tready = d_rsp_rdy;
        #1;
        sample();

        load_ok = (!m_slot_v || d_add_rdy) && (m_tags.size() < MAX_INFLIGHT);
        g = -1;
        if (load_ok)
            for (int k = 0; k < N; k++)
                if (g < 0 && d_req_v[(m_rr + k) % N]) g = (m_rr + k) % N;
        exp_rt = '0;
        if (g >= 0) exp_rt[g] = 1'b1;
        head   = (m_tags.size() > 0) ? m_tags[0] : -1;
        exp_rv = '0;
        exp_rr = 1'b0;
        if (head >= 0) begin
            if (res_v) exp_rv[head] = 1'b1;
            exp_rr = d_rsp_rdy[head];
        end
        pop = res_v && exp_rr;

        chk("req_tready", s_req_tready, exp_rt);
        chk("add_tvalid", s_add_tvalid, m_slot_v);
        if (m_slot_v) chk("add_tdata", s_add_tdata, m_slot_d);
        chk("rsp_tvalid", s_rsp_tvalid, exp_rv);
        chk("res_tready", s_res_tready, exp_rr);
        chk("rsp_tdata", s_rsp_tdata, {N{res_d}});
        chk("inflight", s_inflight, m_tags.size());
        chk("err", s_err, m_err);
        chk("credit_cap", (|s_req_tready) && (s_inflight == cnt_t'(MAX_INFLIGHT)), 1'b0);
        if (pop) chk("rsp_sum", s_rsp_tdata[head*32 +: 32], m_sums[0]);

        @(posedge aclk);
        cyc++;
        if (pop && !d_force_res) begin
            void'(ad_sum.pop_front());
            void'(ad_rdy.pop_front());
        end
        if (s_add_tvalid && d_add_rdy) begin
            ad_sum.push_back(int'((s_add_tdata[31:0] + s_add_tdata[63:32]) % 32'd100));
            ad_rdy.push_back(cyc + LAT);
        end
        if (pop) begin
            void'(m_tags.pop_front());
            void'(m_sums.pop_front());
        end
        if (res_v && head < 0) m_err = 1'b1;
        if (g >= 0) begin
            m_tags.push_back(g);
            m_sums.push_back(int'((d_a[g] + d_b[g]) % 32'd100));
            m_slot_v = 1'b1;
            m_slot_d = {d_b[g], d_a[g]};
            m_rr     = (g + 1) % N;
        end else if (d_add_rdy) begin
            m_slot_v = 1'b0;
        end
    endtask

    task automatic do_reset(input bit mid);
        if (mid) begin
            @(posedge aclk);
            #3;
        end else begin
            @(negedge aclk);
        end
        aresetn        = 1'b0;
        bus.req_tvalid = '0;
        bus.req_tdata  = '0;
        bus.res_tvalid = 1'b0;
        bus.res_tdata  = '0;
        bus.rsp_tready = '0;
        bus.add_tready = 1'b0;
        #1;
        sample();
        chk("rst_add_tvalid", s_add_tvalid, 1'b0);
        chk("rst_add_tdata", s_add_tdata, 64'h0);
        chk("rst_inflight", s_inflight, 0);
        chk("rst_err", s_err, 1'b0);
        chk("rst_req_tready", s_req_tready, 4'b0000);
        chk("rst_res_tready", s_res_tready, 1'b0);
        chk("rst_rsp_tvalid", s_rsp_tvalid, 4'b0000);
        repeat (2) @(posedge aclk);
        cyc += 2;
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            d_a[i] = '0;
            d_b[i] = '0;
        end
        model_reset();
        do_reset(1'b0);

        // single requester 1: 5 + 7
        d_a[1] = 32'd5;
        d_b[1] = 32'd7;
        d_req_v = 4'b0010;
        step();
        chk("t1_grant", s_req_tready, 4'b0010);
        d_req_v = '0;
        step();
        chk("t1_add_tvalid", s_add_tvalid, 1'b1);
        chk("t1_add_tdata", s_add_tdata, {32'd7, 32'd5});
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_rsp_tvalid != '0) break;
        end
        chk("t1_rsp_lane", s_rsp_tvalid, 4'b0010);
        chk("t1_rsp_data", s_rsp_tdata[63:32], 32'd12);
        repeat (3) step();

        // all requesters valid: strict rotation from 0
        do_reset(1'b0);
        for (int i = 0; i < N; i++) begin
            d_a[i] = 32'(i + 3);
            d_b[i] = 32'(i * 11);
        end
        d_req_v = '1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t2_grant%0d", i), s_req_tready, 4'b0001 << (i % 4));
        end
        d_req_v = '0;
        repeat (12) step();

        // credit limit with responses blocked
        do_reset(1'b0);
        d_req_v   = '1;
        d_rsp_rdy = '0;
        acc = 0;
        repeat (14) begin
            step();
            if (s_req_tready != '0) acc++;
        end
        chk("t3_accepts", acc, 8);
        chk("t3_inflight", s_inflight, 8);
        chk("t3_blocked", s_req_tready, 4'b0000);
        d_rsp_rdy = '1;
        step();
        chk("t3_release_cycle", s_req_tready, 4'b0000);
        d_rsp_rdy = '0;
        acc = 0;
        repeat (4) begin
            step();
            if (s_req_tready != '0) acc++;
        end
        chk("t3_one_more", acc, 1);
        d_req_v   = '0;
        d_rsp_rdy = '1;
        repeat (25) step();
        chk("t3_drained", s_inflight, 0);

        // adder stall holds the slot
        do_reset(1'b0);
        d_a[0] = 32'd1;
        d_b[0] = 32'd10;
        d_add_rdy = 1'b0;
        d_req_v   = 4'b0001;
        step();
        chk("t4_first_grant", s_req_tready, 4'b0001);
        d_req_v = '1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (s_req_tready != '0) acc++;
            chk($sformatf("t4_hold%0d", i), s_add_tdata, {32'd10, 32'd1});
        end
        chk("t4_no_grant", acc, 0);
        d_add_rdy = 1'b1;
        step();
        chk("t4_resume", s_req_tready, 4'b0010);
        d_req_v = '0;
        repeat (12) step();

        // head-of-line block: head lane 0 not ready, lane 2 ready
        do_reset(1'b0);
        d_rsp_rdy = 4'b0100;
        d_req_v   = 4'b0001;
        step();
        d_req_v = 4'b0100;
        step();
        d_req_v = '0;
        repeat (6) step();
        chk("t5_rsp_tvalid", s_rsp_tvalid, 4'b0001);
        chk("t5_res_tready", s_res_tready, 1'b0);
        chk("t5_inflight", s_inflight, 2);
        d_rsp_rdy = '1;
        repeat (10) step();
        chk("t5_drained", s_inflight, 0);

        // result with no tag pending
        do_reset(1'b0);
        d_force_res = 1'b1;
        step();
        chk("t6_res_tready", s_res_tready, 1'b0);
        chk("t6_rsp_tvalid", s_rsp_tvalid, 4'b0000);
        d_force_res = 1'b0;
        step();
        chk("t6_err", s_err, 1'b1);
        step();
        chk("t6_err_sticky", s_err, 1'b1);

        // random traffic with a mid-stream reset
        do_reset(1'b0);
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset(1'b1);
            d_req_v   = N'($urandom_range(0, 15));
            d_add_rdy = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                d_a[k]       = 32'($urandom_range(0, 49));
                d_b[k]       = 32'($urandom_range(0, 49));
                d_rsp_rdy[k] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        d_req_v   = '0;
        d_rsp_rdy = '1;
        d_add_rdy = 1'b1;
        repeat (30) step();
        chk("final_inflight", s_inflight, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
